// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin burst arbiter steering a 4:1 mux select with valid/ready qualification
module rr_sel_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    input  logic [3:0] i_last,
    input  logic       i_ready,
    output logic       o_sel0,
    output logic       o_sel1,
    output logic [3:0] o_gnt,
    output logic       o_valid,
    output logic       o_busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state, state_nx;
    logic [1:0] s, s_nx, ptr, ptr_nx, pick;
    logic [3:0] cnt, cnt_nx;
    logic       xfer, done;
    // Highest priority is ptr+1; falls back to ptr itself when only it requests
    always_comb begin
        pick = ptr;
        for (int k = 3; k >= 1; k--)
            if (i_req[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
    assign o_busy  = state == GRANT;
    assign o_valid = o_busy && i_req[s];
    assign o_gnt   = o_busy ? 4'b0001 << s : 4'b0000;
    assign {o_sel1, o_sel0} = s;
    assign xfer = o_valid && i_ready;
    assign done = !i_req[s] || (xfer && (i_last[s] || cnt + 4'd1 == 4'(MAX_BURST)));
    always_comb begin
        state_nx = state;
        s_nx     = s;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            if (|i_req) begin
                state_nx = GRANT;
                s_nx     = pick;
                cnt_nx   = 4'd0;
            end
        end else if (done) begin
            state_nx = IDLE;
            ptr_nx   = s;
            cnt_nx   = 4'd0;
        end else if (xfer) begin
            cnt_nx = cnt + 4'd1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            s     <= 2'd0;
            ptr   <= 2'd3;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            s     <= s_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: vector table, directed corner sequences and random run against a grant-level model
module tb_rr_sel_arbiter;
    localparam int MB = 4;
    logic       clk = 1'b0, rst_n = 1'b0, ready = 1'b0;
    logic [3:0] req = '0, last = '0;
    logic       sel0, sel1, valid, busy;
    logic [3:0] gnt;
    int         errs = 0, checks = 0;
    logic [7:0] snap;
    bit         model_on = 0;
    int         m_owner, m_ptr, m_beats;
    logic [1:0] m_sel;

    rr_sel_arbiter #(.MAX_BURST(MB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_last(last), .i_ready(ready),
        .o_sel0(sel0), .o_sel1(sel1), .o_gnt(gnt), .o_valid(valid), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic [3:0] rq, lt;
        logic       rd;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {gnt, sel, valid, busy} derived from who owns the grant
    function automatic logic [7:0] m_out(input logic [3:0] rq);
        logic       b  = m_owner >= 0;
        logic [3:0] g  = b ? 4'(1 << m_owner) : 4'b0000;
        logic       v  = b ? rq[m_owner[1:0]] : 1'b0;
        return {g, m_sel, v, b};
    endfunction

    task automatic m_step(input logic rn, input logic [3:0] rq, lt, input logic rd);
        if (!rn) begin
            m_owner = -1; m_ptr = 3; m_beats = 0; m_sel = 2'd0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 4 && m_owner < 0; k++)
                if (rq[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            if (m_owner >= 0) begin m_sel = 2'(m_owner); m_beats = 0; end
        end else if (!rq[m_owner]) begin
            m_ptr = m_owner; m_owner = -1;
        end else if (rd) begin
            m_beats++;
            if (lt[m_owner] || m_beats == MB) begin m_ptr = m_owner; m_owner = -1; end
        end
    endtask

    task automatic cycle(input logic rn, input logic [3:0] rq, lt, input logic rd);
        rst_n = rn; req = rq; last = lt; ready = rd;
        @(negedge clk);
        snap = {gnt, sel1, sel0, valid, busy};
        if (model_on) chk("model", 32'(snap), 32'(m_out(rq)));
        @(posedge clk);
        m_step(rn, rq, lt, rd);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 4'b0, 4'b0, 1'b0);
        cycle(1'b0, 4'b0, 4'b0, 1'b0);
        model_on = 1;
    endtask

    initial begin
        vec_t vt[12];
        int   owners[$], lens[$];
        logic pb;
        vt[0]  = '{1, 4'b0001, 4'b0001, 1, {4'b0000, 2'b00, 1'b0, 1'b0}};
        vt[1]  = '{1, 4'b0001, 4'b0001, 1, {4'b0001, 2'b00, 1'b1, 1'b1}};
        vt[2]  = '{1, 4'b0000, 4'b0000, 1, {4'b0000, 2'b00, 1'b0, 1'b0}};
        vt[3]  = '{1, 4'b0010, 4'b0000, 1, {4'b0000, 2'b00, 1'b0, 1'b0}};
        vt[4]  = '{1, 4'b0010, 4'b0000, 1, {4'b0010, 2'b01, 1'b1, 1'b1}};
        vt[5]  = '{1, 4'b0010, 4'b0000, 1, {4'b0010, 2'b01, 1'b1, 1'b1}};
        vt[6]  = '{1, 4'b1001, 4'b0000, 1, {4'b0010, 2'b01, 1'b0, 1'b1}};
        vt[7]  = '{1, 4'b1001, 4'b0000, 1, {4'b0000, 2'b01, 1'b0, 1'b0}};
        vt[8]  = '{1, 4'b1001, 4'b0000, 0, {4'b1000, 2'b11, 1'b1, 1'b1}};
        vt[9]  = '{0, 4'b1001, 4'b0000, 0, {4'b1000, 2'b11, 1'b1, 1'b1}};
        vt[10] = '{1, 4'b1111, 4'b0000, 0, {4'b0000, 2'b00, 1'b0, 1'b0}};
        vt[11] = '{1, 4'b1111, 4'b0000, 1, {4'b0001, 2'b00, 1'b1, 1'b1}};
        do_reset();
        foreach (vt[i]) begin
            cycle(vt[i].rn, vt[i].rq, vt[i].lt, vt[i].rd);
            chk($sformatf("vec%0d", i), 32'(snap), 32'(vt[i].exp));
        end

        // All four requesting: four-beat bursts in order 0,1,2,3,0 with one idle bubble between
        do_reset();
        pb = 0;
        for (int c = 0; c < 26; c++) begin
            cycle(1'b1, 4'b1111, 4'b0000, 1'b1);
            if (snap[0]) begin
                if (!pb) begin owners.push_back(int'(snap[3:2])); lens.push_back(0); end
                if (snap[1]) lens[lens.size() - 1]++;
            end
            pb = snap[0];
        end
        chk("rr_count", 32'(owners.size()), 32'd5);
        for (int i = 0; i < 5 && i < owners.size(); i++) begin
            chk($sformatf("rr_owner%0d", i), 32'(owners[i]), 32'(i % 4));
            chk($sformatf("rr_len%0d", i), 32'(lens[i]), 32'(MB));
        end

        // Requester 2 stalled three cycles, then four accepted beats end the grant
        do_reset();
        cycle(1'b1, 4'b0100, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 4'b0100, 4'b0000, 1'b0);
            chk("stall_out", 32'(snap), 32'({4'b0100, 2'b10, 1'b1, 1'b1}));
        end
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, 4'b0100, 4'b0000, 1'b1);
            chk("stall_beat", 32'(snap[1:0]), 32'd3);
        end
        cycle(1'b1, 4'b0000, 4'b0000, 1'b1);
        chk("stall_release", 32'(snap), 32'({4'b0000, 2'b10, 1'b0, 1'b0}));

        // i_last on the fourth beat: one release, one bubble, pointer advances once
        do_reset();
        cycle(1'b1, 4'b0001, 4'b0000, 1'b1);
        for (int c = 0; c < 3; c++) cycle(1'b1, 4'b0001, 4'b0000, 1'b1);
        cycle(1'b1, 4'b0011, 4'b0001, 1'b1);
        chk("coinc_beat4", 32'(snap), 32'({4'b0001, 2'b00, 1'b1, 1'b1}));
        cycle(1'b1, 4'b0011, 4'b0000, 1'b1);
        chk("coinc_bubble", 32'(snap[0]), 32'd0);
        cycle(1'b1, 4'b0011, 4'b0000, 1'b1);
        chk("coinc_next", 32'(snap), 32'({4'b0010, 2'b01, 1'b1, 1'b1}));

        // Random traffic checked every cycle against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [3:0] rq = req;
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            cycle($urandom_range(0, 99) != 0, rq, 4'($urandom & $urandom),
                  $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
